display_mux: RTL

Time-multiplexed driver for an N-digit common-anode seven-segment display. It takes a packed vector of 4-bit hex digits, decimal points and per-digit enables, and scans one digit per refresh slot. Segment outputs are active-low; each slot starts with an anti-ghosting blank interval. It sits between the datapath, which supplies the values, and the board's display pins, and supersedes the single-digit combinational decoder with a parametrised, registered, scanned driver.

---
 rtl/display_mux_if.sv | 31 +++
 rtl/display_mux.sv | 120 ++++++++++++
 2 files changed

// File: rtl/display_mux_if.sv
// display_mux_if: bundle between the datapath and the scanned display driver.
//   valores     : 4*N_DIGITS hex digits, digit 0 in bits [3:0] (rightmost)
//   puntos      : decimal point request per digit, 1 = lit
//   habilitar   : per-digit enable, 1 = shown
//   supr_ceros  : leading-zero suppression, 1 = on
//   seg/dp      : active-low segments {a..g} and decimal point
//   anodos      : active-low digit select, at most one low
//   fin_barrido : one-cycle pulse per completed frame
// master = datapath side, slave = display_mux.
interface display_mux_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] valores;
  logic [N_DIGITS-1:0]   puntos;
  logic [N_DIGITS-1:0]   habilitar;
  logic                  supr_ceros;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   anodos;
  logic                  fin_barrido;

  modport master (
    output valores, puntos, habilitar, supr_ceros,
    input  seg, dp, anodos, fin_barrido
  );

  modport slave (
    input  valores, puntos, habilitar, supr_ceros,
    output seg, dp, anodos, fin_barrido
  );
endinterface

// File: rtl/display_mux.sv
// display_mux: time-multiplexed common-anode seven-segment driver.
// Scans one digit per REFRESH_DIV-cycle slot; the first BLANK_CYCLES of every
// slot keep all anodes off to avoid ghosting. Inputs are sampled into shadow
// registers only at frame end so a frame is always shown coherently.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : display_mux_if slave modport (values in, pins out)
// All pin outputs are registered (1-cycle latency from the idx/cnt state).
module display_mux #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          reset,
  display_mux_if.slave  bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [N_DIGITS-1:0][3:0]  sh_valores;
  logic [N_DIGITS-1:0]       sh_puntos;
  logic [N_DIGITS-1:0]       sh_habilitar;
  logic                      sh_supr;

  logic                      slot_end, frame_end;
  logic [N_DIGITS:0]         zero_up;  // digits g..N-1 all zero
  logic [N_DIGITS-1:0]       supp;

  logic                      vis;
  logic [6:0]                seg_nxt, seg_q;
  logic                      dp_nxt, dp_q;
  logic [N_DIGITS-1:0]       an_nxt, an_q;
  logic                      fin_q;

  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));

  // Leading-zero chain runs from the most significant digit downward.
  assign zero_up[N_DIGITS] = 1'b1;
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_zero
    assign zero_up[g] = (sh_valores[g] == 4'h0) && zero_up[g+1];
    if (g == 0) begin : g_d0
      assign supp[g] = 1'b0;  // rightmost digit always shows, even "0"
    end else begin : g_dn
      assign supp[g] = sh_supr && zero_up[g];
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  // A hidden digit still owns its slot; only the pins go dark.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    vis     = sh_habilitar[idx] && !supp[idx] && (int'(cnt) >= BLANK_CYCLES);
    if (vis) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = decode(sh_valores[idx]);
      dp_nxt      = ~sh_puntos[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      sh_valores   <= '0;
      sh_puntos    <= '0;
      sh_habilitar <= '0;
      sh_supr      <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      fin_q        <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end)
        idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
      if (frame_end) begin
        sh_valores   <= bus.valores;
        sh_puntos    <= bus.puntos;
        sh_habilitar <= bus.habilitar;
        sh_supr      <= bus.supr_ceros;
      end
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      an_q  <= an_nxt;
      fin_q <= frame_end;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.anodos      = an_q;
  assign bus.fin_barrido = fin_q;
endmodule
